// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: pipeline-stage register numbers and control bits
// going in, forwarding selects, stalls, flushes and divider status coming out.
interface hazard_ctrl_if;
  logic [4:0] rs_d;
  logic [4:0] rt_d;
  logic [4:0] rs_e;
  logic [4:0] rt_e;
  logic [4:0] writereg_e;
  logic [4:0] writereg_m;
  logic [4:0] writereg_w;
  logic       regwrite_e;
  logic       regwrite_m;
  logic       regwrite_w;
  logic       memtoreg_e;
  logic       memtoreg_m;
  logic       branch_d;
  logic       div_start_e;
  logic       flush_exc;

  logic [1:0] forward_ae;
  logic [1:0] forward_be;
  logic       forward_ad;
  logic       forward_bd;
  logic       stall_f;
  logic       stall_d;
  logic       stall_e;
  logic       flush_d;
  logic       flush_e;
  logic       flush_m;
  logic       div_busy;
  logic       div_done;

  // Pipeline side: drives stage information, consumes hazard decisions.
  modport master (
    output rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w,
           regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m,
           branch_d, div_start_e, flush_exc,
    input  forward_ae, forward_be, forward_ad, forward_bd,
           stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
           div_busy, div_done
  );

  // Hazard unit side.
  modport slave (
    input  rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w,
           regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m,
           branch_d, div_start_e, flush_exc,
    output forward_ae, forward_be, forward_ad, forward_bd,
           stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
           div_busy, div_done
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: operand forwarding into EX and
// the ID compare, load-use and branch stalls, exception flushes, and a
// multi-cycle divider sequencer (IDLE -> BUSY for DIV_CYCLES -> DONE).
module hazard_ctrl #(
  parameter int unsigned DIV_CYCLES = 32  // legal range 2..63
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam logic [5:0] CNT_LOAD = 6'(DIV_CYCLES - 1);

  div_state_t state, state_nxt;
  logic [5:0] cnt, cnt_nxt;
  logic       lwstall;
  logic       brstall;
  logic       divstall;

  // EX operand forwarding: MEM result wins over WB; register 0 is never forwarded.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    bus.forward_ae = 2'b00;
    bus.forward_be = 2'b00;
    if (bus.regwrite_m && (bus.writereg_m != 5'd0) && (bus.writereg_m == bus.rs_e))
      bus.forward_ae = 2'b01;
    else if (bus.regwrite_w && (bus.writereg_w != 5'd0) && (bus.writereg_w == bus.rs_e))
      bus.forward_ae = 2'b10;
    if (bus.regwrite_m && (bus.writereg_m != 5'd0) && (bus.writereg_m == bus.rt_e))
      bus.forward_be = 2'b01;
    else if (bus.regwrite_w && (bus.writereg_w != 5'd0) && (bus.writereg_w == bus.rt_e))
      bus.forward_be = 2'b10;
  end

  // ID compare forwarding only ever takes the MEM result.
  assign bus.forward_ad = bus.regwrite_m && (bus.writereg_m != 5'd0) &&
                          (bus.writereg_m == bus.rs_d);
  assign bus.forward_bd = bus.regwrite_m && (bus.writereg_m != 5'd0) &&
                          (bus.writereg_m == bus.rt_d);

  // Load-use: the load in EX cannot supply its data until after MEM.
  assign lwstall = bus.memtoreg_e &&
                   ((bus.rs_d == bus.rt_e) || (bus.rt_d == bus.rt_e));

  // Branch in ID needs an operand still being produced by EX or loaded in MEM.
  assign brstall = bus.branch_d && (
      (bus.regwrite_e && (bus.writereg_e != 5'd0) &&
       ((bus.writereg_e == bus.rs_d) || (bus.writereg_e == bus.rt_d))) ||
      (bus.memtoreg_m && (bus.writereg_m != 5'd0) &&
       ((bus.writereg_m == bus.rs_d) || (bus.writereg_m == bus.rt_d))));

  // Divider state register and cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 6'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Divider next state, counter update and status outputs; an exception
  // flush drops back to IDLE from anywhere and suppresses the done pulse.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    divstall     = 1'b0;
    bus.div_busy = (state == BUSY);
    bus.div_done = (state == DONE) && !bus.flush_exc;

    if (bus.flush_exc) begin
      state_nxt = IDLE;
      cnt_nxt   = 6'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.div_start_e) begin
            state_nxt = BUSY;
            cnt_nxt   = CNT_LOAD;
          end
        end
        BUSY: begin
          if (cnt == 6'd0) state_nxt = DONE;
          else             cnt_nxt   = cnt - 6'd1;
        end
        DONE:    state_nxt = IDLE;  // no same-cycle restart out of DONE
        default: state_nxt = IDLE;
      endcase
    end

    if (((state == IDLE) && bus.div_start_e && !bus.flush_exc) || (state == BUSY))
      divstall = 1'b1;
  end

  // Stall and flush combination; a flush request overrides every stall, and a
  // divide stall freezes EX so the bubble for load/branch stalls is withheld.
  always_comb begin
    bus.stall_f = (lwstall || brstall || divstall) && !bus.flush_exc;
    bus.stall_d = bus.stall_f;
    bus.stall_e = divstall && !bus.flush_exc;
    bus.flush_e = ((lwstall || brstall) && !divstall) || bus.flush_exc;
    bus.flush_d = bus.flush_exc;
    bus.flush_m = bus.flush_exc;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the driver applies directed vectors just
// after each rising edge and queues the hand-computed output vector; the
// monitor compares the DUT outputs against the queue on every falling edge.
module tb_hazard_ctrl;

  typedef struct {
    string      name;
    logic [13:0] vec;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t q[$];

  hazard_ctrl_if bus();

  hazard_ctrl #(.DIV_CYCLES(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack outputs as {fwd_ae, fwd_be, fwd_ad, fwd_bd, stall_f, stall_d,
  // stall_e, flush_d, flush_e, flush_m, div_busy, div_done}.
  function automatic logic [13:0] e(input logic [1:0] fa, input logic [1:0] fb,
                                    input logic fad, input logic fbd,
                                    input logic sfd, input logic se,
                                    input logic fd, input logic fe, input logic fm,
                                    input logic busy, input logic done);
    return {fa, fb, fad, fbd, sfd, sfd, se, fd, fe, fm, busy, done};
  endfunction

  task automatic clr();
    bus.rs_d = '0; bus.rt_d = '0; bus.rs_e = '0; bus.rt_e = '0;
    bus.writereg_e = '0; bus.writereg_m = '0; bus.writereg_w = '0;
    bus.regwrite_e = 1'b0; bus.regwrite_m = 1'b0; bus.regwrite_w = 1'b0;
    bus.memtoreg_e = 1'b0; bus.memtoreg_m = 1'b0; bus.branch_d = 1'b0;
    bus.div_start_e = 1'b0; bus.flush_exc = 1'b0;
  endtask

  // Queue the expectation for the current inputs and advance one cycle.
  task automatic cyc(input string name, input logic [13:0] v);
    exp_t x;
    x.name = name;
    x.vec  = v;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare against the oldest queued expectation each falling edge.
  initial begin
    exp_t        x;
    logic [13:0] got;
    checks = 0;
    errors = 0;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x   = q.pop_front();
        got = {bus.forward_ae, bus.forward_be, bus.forward_ad, bus.forward_bd,
               bus.stall_f, bus.stall_d, bus.stall_e, bus.flush_d, bus.flush_e,
               bus.flush_m, bus.div_busy, bus.div_done};
        checks++;
        if (got !== x.vec) begin
          errors++;
          $display("FAIL %s got=%b exp=%b (fa fb ad bd sf sd se fd fe fm busy done)",
                   x.name, got, x.vec);
        end
      end
    end
  end

  localparam logic [13:0] Z = 14'd0;

  initial begin
    rst = 1'b1;
    clr();
    @(posedge clk);
    #1;

    // Reset: FSM held idle, combinational paths still live.
    bus.memtoreg_e = 1'b1; bus.rt_e = 5'd9; bus.rs_d = 5'd9;
    cyc("rst_lwstall", e(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
    clr();
    cyc("rst_idle", Z);
    rst = 1'b0;
    cyc("post_rst", Z);

    // Forwarding into EX.
    bus.regwrite_m = 1'b1; bus.writereg_m = 5'd8; bus.rs_e = 5'd8;
    bus.regwrite_w = 1'b1; bus.writereg_w = 5'd8;
    cyc("fwd_ae_mem_prio", e(2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    bus.writereg_m = 5'd0;
    cyc("fwd_ae_wb", e(2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    clr();
    bus.regwrite_m = 1'b1; bus.writereg_m = 5'd5; bus.rt_e = 5'd5;
    bus.rs_d = 5'd5; bus.rt_d = 5'd5;
    cyc("fwd_be_mem_ad_bd", e(0, 2'b01, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    clr();
    bus.writereg_m = 5'd5; bus.rt_e = 5'd5; bus.rs_e = 5'd5;
    bus.regwrite_w = 1'b1; bus.writereg_w = 5'd5;
    cyc("fwd_ab_wb_no_regwr_m", e(2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    clr();
    bus.regwrite_m = 1'b1; bus.regwrite_w = 1'b1;
    cyc("fwd_reg0", Z);

    // Load-use stall, one cycle, via rs_d then rt_d.
    clr();
    bus.memtoreg_e = 1'b1; bus.rt_e = 5'd9; bus.rs_d = 5'd9;
    cyc("lw_rs", e(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
    clr();
    cyc("lw_release", Z);
    bus.memtoreg_e = 1'b1; bus.rt_e = 5'd3; bus.rt_d = 5'd3; bus.rs_d = 5'd1;
    cyc("lw_rt", e(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));

    // Branch hazards.
    clr();
    bus.branch_d = 1'b1; bus.regwrite_e = 1'b1; bus.writereg_e = 5'd4; bus.rs_d = 5'd4;
    cyc("br_ex", e(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
    bus.writereg_e = 5'd0; bus.rs_d = 5'd0;
    cyc("br_reg0", Z);
    clr();
    bus.branch_d = 1'b1; bus.memtoreg_m = 1'b1; bus.writereg_m = 5'd7; bus.rt_d = 5'd7;
    cyc("br_mem_load", e(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
    clr();
    bus.branch_d = 1'b1; bus.writereg_e = 5'd4; bus.rs_d = 5'd4;
    cyc("br_no_regwr", Z);

    // Exception flush, including priority over a branch stall and a start.
    clr();
    bus.flush_exc = 1'b1;
    cyc("flush_idle", e(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
    bus.branch_d = 1'b1; bus.regwrite_e = 1'b1; bus.writereg_e = 5'd4; bus.rs_d = 5'd4;
    cyc("flush_over_br", e(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
    clr();
    bus.div_start_e = 1'b1; bus.flush_exc = 1'b1;
    cyc("flush_blocks_start", e(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
    clr();
    cyc("flush_start_idle", Z);

    // Full divide: start cycle, 32 BUSY cycles, DONE (start held, no restart), IDLE.
    bus.div_start_e = 1'b1;
    cyc("div_start", e(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    clr();
    for (int i = 0; i < 32; i++) cyc("div_busy", e(0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0));
    bus.div_start_e = 1'b1;
    cyc("div_done", e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    clr();
    cyc("div_idle0", Z);
    cyc("div_idle1", Z);

    // Divide with concurrent load-use, then exception at cnt=10.
    bus.div_start_e = 1'b1; bus.memtoreg_e = 1'b1; bus.rt_e = 5'd9; bus.rs_d = 5'd9;
    cyc("div_lw_start", e(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    bus.div_start_e = 1'b0;
    cyc("div_lw_busy", e(0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0));
    clr();
    for (int i = 0; i < 20; i++) cyc("exc_busy", e(0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0));
    bus.flush_exc = 1'b1;
    cyc("exc_req", e(0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0));
    clr();
    for (int i = 0; i < 3; i++) cyc("exc_after", Z);

    // Asynchronous reset between edges during BUSY.
    bus.div_start_e = 1'b1;
    cyc("rst_div_start", e(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    clr();
    for (int i = 0; i < 5; i++) cyc("rst_div_busy", e(0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0));
    #1;
    rst = 1'b1;
    #1;
    cyc("rst_async_abort", Z);
    rst = 1'b0;
    cyc("rst_release0", Z);
    cyc("rst_release1", Z);

    // Bounded drain of any outstanding expectations.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
